// File: rtl/note_scheduler_pkg.sv
// Shared constants and types for the rhythm-game note scheduler.
// Holds the pool geometry, the lane and control keycodes, the FSM state
// encoding and the chart ROM word layout.
package note_scheduler_pkg;

    localparam int unsigned N_SLOTS     = 8;
    localparam int unsigned SLOT_IDX_W  = $clog2(N_SLOTS);
    localparam int unsigned N_LANES     = 4;
    localparam int unsigned LANE_W      = 2;
    localparam int unsigned Y_W         = 10;
    localparam int unsigned NOTE_H      = 40;
    localparam int unsigned Y_START     = 100;
    localparam int unsigned Y_MAX       = 400;
    localparam int unsigned HIT_LO      = 340;
    localparam int unsigned SPEED       = 1;
    localparam int unsigned CHART_AW    = 8;
    localparam int unsigned CHART_DW    = 16;
    localparam int unsigned DELAY_W     = 12;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned COMBO_W     = 8;
    localparam int unsigned KEY_W       = 8;

    localparam logic [KEY_W-1:0] KEY_L       = 8'h50;
    localparam logic [KEY_W-1:0] KEY_D       = 8'h51;
    localparam logic [KEY_W-1:0] KEY_U       = 8'h52;
    localparam logic [KEY_W-1:0] KEY_R       = 8'h4F;
    localparam logic [KEY_W-1:0] START_KEY   = 8'h2C;
    localparam logic [KEY_W-1:0] RESTART_KEY = 8'h01;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_FETCH = 2'd1;
    localparam sched_state_t ST_PLAY  = 2'd2;
    localparam sched_state_t ST_DONE  = 2'd3;

    typedef struct packed {
        logic                evt_end;
        logic                rsvd;
        logic [LANE_W-1:0]   lane;
        logic [DELAY_W-1:0]  delay;
    } chart_evt_t;

    // Keycode that presses a given lane (0=L 1=D 2=U 3=R).
    function automatic logic [KEY_W-1:0] lane_key(input logic [LANE_W-1:0] lane);
        case (lane)
            2'd0:    lane_key = KEY_L;
            2'd1:    lane_key = KEY_D;
            2'd2:    lane_key = KEY_U;
            default: lane_key = KEY_R;
        endcase
    endfunction

endpackage

// File: rtl/note_scheduler_note_slot.sv
// One entry of the on-screen note pool.
// Ports: clk_i/reset_i (sync, active-high); clear_i empties the slot;
// spawn_i loads lane_i at Y_START into an empty slot; free_i retires an
// active note; move_i advances it by SPEED. active_o/lane_o/y_o are the
// registered slot contents; in_window_c_o and at_miss_c_o are
// combinational judgements of the current position.
module note_scheduler_note_slot
    import note_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              spawn_i,
    input  logic              free_i,
    input  logic              move_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic              active_o,
    output logic [LANE_W-1:0] lane_o,
    output logic [Y_W-1:0]    y_o,
    output logic              in_window_c_o,
    output logic              at_miss_c_o
);

    // Thresholds on the sprite top: bottom edge is Y + NOTE_H.
    localparam logic [Y_W-1:0] HIT_Y  = Y_W'(HIT_LO - NOTE_H);
    localparam logic [Y_W-1:0] MISS_Y = Y_W'(Y_MAX - NOTE_H);

    logic              active_q, active_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [Y_W-1:0]    y_q, y_d;

    // Next slot contents; free has priority over move.
    always_comb begin
        active_d = active_q;
        lane_d   = lane_q;
        y_d      = y_q;
        if (clear_i) begin
            active_d = 1'b0;
            lane_d   = '0;
            y_d      = '0;
        end else if (spawn_i && !active_q) begin
            active_d = 1'b1;
            lane_d   = lane_i;
            y_d      = Y_W'(Y_START);
        end else if (active_q && free_i) begin
            active_d = 1'b0;
        end else if (active_q && move_i) begin
            y_d = y_q + Y_W'(SPEED);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q <= 1'b0;
            lane_q   <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            lane_q   <= lane_d;
            y_q      <= y_d;
        end
    end

    assign active_o      = active_q;
    assign lane_o        = lane_q;
    assign y_o           = y_q;
    assign in_window_c_o = active_q && (y_q >= HIT_Y) && (y_q < MISS_Y);
    assign at_miss_c_o   = active_q && (y_q >= MISS_Y);

endmodule

// File: rtl/note_scheduler.sv
// Rhythm-game note scheduler: walks a chart ROM of {lane, delay} events,
// spawns notes into a pool of N_SLOTS slots, moves them each frame and
// judges lane keypresses as hits or misses.
// Ports: frame_clk_i/reset_i (sync, active-high); keycode_i and
// keycode_second_i are the two USB keycodes; chart_addr_o/chart_data_i
// access the chart ROM; slot_active_o/slot_lane_o/slot_y_o expose the pool
// to the sprite mapper; hit_count_o/miss_count_o/combo_o are the score
// totals; busy_o is high in FETCH/PLAY, done_o in DONE.
module note_scheduler
    import note_scheduler_pkg::*;
(
    input  logic                      frame_clk_i,
    input  logic                      reset_i,
    input  logic [KEY_W-1:0]          keycode_i,
    input  logic [KEY_W-1:0]          keycode_second_i,
    output logic [CHART_AW-1:0]       chart_addr_o,
    input  logic [CHART_DW-1:0]       chart_data_i,
    output logic [N_SLOTS-1:0]        slot_active_o,
    output logic [LANE_W*N_SLOTS-1:0] slot_lane_o,
    output logic [Y_W*N_SLOTS-1:0]    slot_y_o,
    output logic [CNT_W-1:0]          hit_count_o,
    output logic [CNT_W-1:0]          miss_count_o,
    output logic [COMBO_W-1:0]        combo_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned CNT_SUM_W   = CNT_W + 1;
    localparam int unsigned COMBO_SUM_W = COMBO_W + 1;

    sched_state_t          state_q, state_d;
    logic [CHART_AW-1:0]   chart_addr_q, chart_addr_d;
    logic [DELAY_W-1:0]    countdown_q, countdown_d;
    logic [LANE_W-1:0]     next_lane_q, next_lane_d;
    logic                  chart_end_q, chart_end_d;
    logic [N_LANES-1:0]    pressed_q, pressed_c, press_edge_c;
    logic [CNT_W-1:0]      hit_q, hit_d, miss_q, miss_d;
    logic [COMBO_W-1:0]    combo_q, combo_d;
    logic                  busy_q, busy_d, done_q, done_d;

    logic [N_SLOTS-1:0]    slot_active, in_win, at_miss;
    logic [LANE_W-1:0]     slot_lane [N_SLOTS];
    logic [Y_W-1:0]        slot_y    [N_SLOTS];
    logic [N_SLOTS-1:0]    slot_spawn, slot_free, hit_free;
    logic                  slot_clear, slot_move, clear_cnt, drop;
    logic [3:0]            miss_inc, miss_pop;
    logic [2:0]            hit_inc, hit_cnt;
    logic                  free_found;
    logic [SLOT_IDX_W-1:0] free_idx;
    logic                  sel_found;
    logic [SLOT_IDX_W-1:0] sel_idx;
    logic [Y_W-1:0]        sel_y;
    logic [CNT_SUM_W-1:0]  hit_sum, miss_sum;
    logic [COMBO_SUM_W-1:0] combo_sum;

    chart_evt_t evt_c;
    logic       unused_rsvd;
    assign evt_c       = chart_evt_t'(chart_data_i);
    assign unused_rsvd = evt_c.rsvd;

    // Note pool.
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        note_scheduler_note_slot u_slot (
            .clk_i         (frame_clk_i),
            .reset_i       (reset_i),
            .clear_i       (slot_clear),
            .spawn_i       (slot_spawn[g]),
            .free_i        (slot_free[g]),
            .move_i        (slot_move),
            .lane_i        (next_lane_q),
            .active_o      (slot_active[g]),
            .lane_o        (slot_lane[g]),
            .y_o           (slot_y[g]),
            .in_window_c_o (in_win[g]),
            .at_miss_c_o   (at_miss[g])
        );
        assign slot_lane_o[LANE_W*g +: LANE_W] = slot_lane[g];
        assign slot_y_o[Y_W*g +: Y_W]          = slot_y[g];
    end

    // Lane press detection from either keycode; only rising edges judge.
    always_comb begin
        pressed_c = '0;
        for (int l = 0; l < N_LANES; l++) begin
            pressed_c[l] = (keycode_i == lane_key(LANE_W'(l))) ||
                           (keycode_second_i == lane_key(LANE_W'(l)));
        end
        press_edge_c = pressed_c & ~pressed_q;
    end

    // Per-lane pick of the in-window note nearest the miss line (ties -> lowest index).
    always_comb begin
        hit_free  = '0;
        hit_cnt   = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_y     = '0;
        for (int l = 0; l < N_LANES; l++) begin
            sel_found = 1'b0;
            sel_idx   = '0;
            sel_y     = '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (in_win[i] && (slot_lane[i] == LANE_W'(l)) &&
                    (!sel_found || (slot_y[i] > sel_y))) begin
                    sel_found = 1'b1;
                    sel_idx   = SLOT_IDX_W'(i);
                    sel_y     = slot_y[i];
                end
            end
            if (press_edge_c[l] && sel_found) begin
                hit_free[sel_idx] = 1'b1;
                hit_cnt           = hit_cnt + 3'd1;
            end
        end
    end

    // Lowest-index empty slot and count of notes past the miss line.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        miss_pop   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_IDX_W'(i);
            end
            miss_pop = miss_pop + 4'(at_miss[i]);
        end
    end

    // Scheduler FSM next state and slot controls.
    always_comb begin
        state_d      = state_q;
        chart_addr_d = chart_addr_q;
        countdown_d  = countdown_q;
        next_lane_d  = next_lane_q;
        chart_end_d  = chart_end_q;
        slot_clear   = 1'b0;
        slot_spawn   = '0;
        slot_free    = '0;
        slot_move    = 1'b0;
        clear_cnt    = 1'b0;
        drop         = 1'b0;
        miss_inc     = '0;
        hit_inc      = '0;
        case (state_q)
            ST_IDLE: begin
                if (keycode_i == START_KEY) begin
                    state_d      = ST_FETCH;
                    slot_clear   = 1'b1;
                    clear_cnt    = 1'b1;
                    chart_end_d  = 1'b0;
                    countdown_d  = '0;
                    chart_addr_d = '0;
                end
            end
            ST_FETCH: begin
                next_lane_d = evt_c.lane;
                countdown_d = evt_c.delay;
                if (evt_c.evt_end) begin
                    chart_end_d = 1'b1;
                end
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                slot_free = at_miss | hit_free;
                slot_move = 1'b1;
                miss_inc  = miss_pop;
                hit_inc   = hit_cnt;
                if (chart_end_q && (slot_active == '0)) begin
                    state_d = ST_DONE;
                end else if (!chart_end_q) begin
                    if (countdown_q == '0) begin
                        if (free_found) begin
                            slot_spawn[free_idx] = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                        chart_addr_d = chart_addr_q + CHART_AW'(1);
                        state_d      = ST_FETCH;
                    end else begin
                        countdown_d = countdown_q - DELAY_W'(1);
                    end
                end
            end
            default: begin
                if (keycode_i == RESTART_KEY) begin
                    state_d      = ST_IDLE;
                    chart_addr_d = '0;
                end
            end
        endcase
        busy_d = (state_d == ST_FETCH) || (state_d == ST_PLAY);
        done_d = (state_d == ST_DONE);
    end

    // Saturating score totals; any miss or dropped spawn breaks the combo.
    always_comb begin
        hit_sum   = {1'b0, hit_q} + CNT_SUM_W'(hit_inc);
        miss_sum  = {1'b0, miss_q} + CNT_SUM_W'(miss_inc) + CNT_SUM_W'(drop);
        combo_sum = {1'b0, combo_q} + COMBO_SUM_W'(hit_inc);
        hit_d     = hit_sum[CNT_W] ? '1 : hit_sum[CNT_W-1:0];
        miss_d    = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
        combo_d   = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
        if ((miss_inc != '0) || drop) begin
            combo_d = '0;
        end
        if (clear_cnt) begin
            hit_d   = '0;
            miss_d  = '0;
            combo_d = '0;
        end
    end

    always_ff @(posedge frame_clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            chart_addr_q <= '0;
            countdown_q  <= '0;
            next_lane_q  <= '0;
            chart_end_q  <= 1'b0;
            pressed_q    <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            combo_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            chart_addr_q <= chart_addr_d;
            countdown_q  <= countdown_d;
            next_lane_q  <= next_lane_d;
            chart_end_q  <= chart_end_d;
            pressed_q    <= pressed_c;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            combo_q      <= combo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign chart_addr_o  = chart_addr_q;
    assign slot_active_o = slot_active;
    assign hit_count_o   = hit_q;
    assign miss_count_o  = miss_q;
    assign combo_o       = combo_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
